// File: rtl/rdn_pkg.sv
// Shared definitions for the image-queue front end of the angle network:
// sequencer state encoding and default image / angle-class geometry.
package rdn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fsm_state_t;

    localparam int DEF_IMG_H    = 5;
    localparam int DEF_IMG_W    = 80;
    localparam int DEF_PIX_W    = 8;
    localparam int DEF_NUM_ANG  = 36;
    localparam int DEF_IMG_BITS = DEF_IMG_H * DEF_IMG_W * DEF_PIX_W;

endpackage

// File: rtl/rdn_img_ring.sv
// DEPTH-slot image ring buffer: storage, read/write pointers and fill count.
// The head slot (dout) is only rewritten once it has been popped.
module rdn_img_ring #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] cnt
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wp_q;
    logic [PTR_W-1:0] rp_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp_q];
    assign cnt     = cnt_q;

    // Image storage carries no reset; only slots counted by cnt are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp_q] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wp_q <= wp_q + 1'b1;
            end
            if (do_pop) begin
                rp_q <= rp_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/rdn_fp_queue.sv
// Buffers images, launches the angle network one image at a time and presents
// each image with its result. Optional macro RDN_FP_QUEUE_ARGMAX_EN adds a registered angle index encoder.
module rdn_fp_queue
    import rdn_pkg::*;
#(
    parameter int IMG_H   = DEF_IMG_H,
    parameter int IMG_W   = DEF_IMG_W,
    parameter int PIX_W   = DEF_PIX_W,
    parameter int DEPTH   = 4,
    parameter int NUM_ANG = DEF_NUM_ANG,
    localparam int IMG_BITS = IMG_H * IMG_W * PIX_W,
    localparam int IDX_W    = $clog2(NUM_ANG) + 1,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_weights,
    input  logic                weight_valid,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IMG_BITS-1:0] in_img,
    output logic                nn_start,
    output logic [IMG_BITS-1:0] nn_img,
    input  logic                nn_done,
    input  logic [NUM_ANG-1:0]  nn_angle,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IMG_BITS-1:0] q,
    output logic [NUM_ANG-1:0]  angle_out,
    output logic [IDX_W-1:0]    angle_idx,
    output logic [CNT_W-1:0]    occupancy,
    output logic [1:0]          dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // A raised valid is held, with its payload stable, until it transfers;
    // ready may change freely and never depends combinationally on valid.

    fsm_state_t          state_q;
    fsm_state_t          state_d;
    logic                weights_ok_q;
    logic                ring_full;
    logic                ring_empty;
    logic                pop;
    logic                capture;
    logic [IMG_BITS-1:0] head_img;
    logic [NUM_ANG-1:0]  angle_q;

    rdn_img_ring #(
        .DEPTH (DEPTH),
        .W     (IMG_BITS)
    ) u_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (pop),
        .din   (in_img),
        .dout  (head_img),
        .full  (ring_full),
        .empty (ring_empty),
        .cnt   (occupancy)
    );

    assign in_ready  = !ring_full;
    assign nn_img    = head_img;
    assign q         = head_img;
    assign angle_out = angle_q;
    assign dbg_state = state_q;

    // A reload pulse beats a simultaneous weight_valid level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights_ok_q <= 1'b0;
        end else if (load_weights) begin
            weights_ok_q <= 1'b0;
        end else if (weight_valid) begin
            weights_ok_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Weight invalidation only gates new launches; a run already under way
    // finishes and its result stays presented until accepted.
    always_comb begin
        state_d  = state_q;
        nn_start = 1'b0;
        out_valid = 1'b0;
        pop      = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!ring_empty && weights_ok_q) begin
                    nn_start = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (nn_done) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_q <= '0;
        end else if (capture) begin
            angle_q <= nn_angle;
        end
    end

`ifdef RDN_FP_QUEUE_ARGMAX_EN
    logic [IDX_W-1:0] idx_enc;
    logic [IDX_W-1:0] angle_idx_q;

    // Scan downward so the lowest set bit wins; no bit set gives MSB only.
    always_comb begin
        idx_enc = {1'b1, {(IDX_W-1){1'b0}}};
        for (int i = NUM_ANG - 1; i >= 0; i--) begin
            if (nn_angle[i]) begin
                idx_enc = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle_idx_q <= '0;
        end else if (capture) begin
            angle_idx_q <= idx_enc;
        end
    end

    assign angle_idx = angle_idx_q;
`else
    assign angle_idx = '0;
`endif

endmodule

// File: doc/rdn_fp_queue.md
RDN_FP_QUEUE -- requirements
Module: rdn_fp_queue

Interface
REQ-001 SHALL have parameter IMG_H, default 5, image rows.
REQ-002 SHALL have parameter IMG_W, default 80, image columns.
REQ-003 SHALL have parameter PIX_W, default 8, bits per pixel.
REQ-004 SHALL have parameter DEPTH, default 4, image slots buffered (power of two, >=2).
REQ-005 SHALL have parameter NUM_ANG, default 36, angle classes from network.
REQ-006 clk  input  1  clock; rst_n  input  1  reset, asynchronous, active-low.
REQ-007 load_weights  input  1  pulse: weight reload begins, current weights invalid.
REQ-008 weight_valid  input  1  level: weight loader finished.
REQ-009 in_valid  input  1  / in_ready  output  1  image input handshake.
REQ-010 in_img  input  IMG_H*IMG_W*PIX_W  flattened image, row 0 pixel 0 in LSBs.
REQ-011 nn_start  output  1  one-cycle pulse launching network; nn_img  output  IMG_H*IMG_W*PIX_W  network operand.
REQ-012 nn_done  input  1  network completion pulse; nn_angle  input  NUM_ANG  network one-hot-ish score bits.
REQ-013 out_valid  output  1  / out_ready  input  1  result handshake.
REQ-014 q  output  IMG_H*IMG_W*PIX_W  image paired with result; angle_out  output  NUM_ANG  captured nn_angle.
REQ-015 angle_idx  output  $clog2(NUM_ANG)+1  encoded angle, MSB = no bit set.
REQ-016 occupancy  output  $clog2(DEPTH)+1  images held (queued + in-flight + presented).

Function
REQ-017 Ring buffer of DEPTH slots, write pointer wp, read pointer rp, count cnt; in_ready = (cnt < DEPTH).
REQ-018 in_valid && in_ready writes in_img to slot[wp], wp increments mod DEPTH, cnt+1, same edge.
REQ-019 weights_ok flag: cleared by load_weights, set on first cycle weight_valid=1 with load_weights=0; load_weights wins if both.
REQ-020 FSM states IDLE, RUN, HOLD; reset to IDLE.
REQ-021 IDLE -> RUN when cnt>0 and weights_ok; nn_start=1 that cycle only.
REQ-022 nn_img = slot[rp] combinationally in all states; slot[rp] never overwritten while cnt>0 (guaranteed by REQ-017).
REQ-023 RUN -> HOLD on nn_done; angle_out <= nn_angle same edge; nn_done in IDLE/HOLD ignored.
REQ-024 HOLD: out_valid=1, q=slot[rp]; out_valid && out_ready pops slot (rp+1, cnt-1) and returns to IDLE.
REQ-025 Simultaneous push and pop: cnt unchanged, both pointers advance.
REQ-026 Earliest restart: IDLE entered after pop may start next image on following cycle (one bubble, fixed).
REQ-027 load_weights during RUN: in-flight run completes and is presented; no new start until weights_ok.
REQ-028 load_weights during HOLD: result remains valid, out_valid not dropped.
REQ-029 out_valid, q, angle_out stable while out_valid && !out_ready.
REQ-030 occupancy = cnt.

Reset
REQ-031 rst_n low: state IDLE, wp=rp=cnt=0, weights_ok=0, nn_start=0, out_valid=0, angle_out=0, angle_idx=0; in_ready=1 after reset.
REQ-032 Slot contents need not reset; q and nn_img undefined-but-unused while cnt=0.
REQ-033 Reset mid-RUN discards in-flight image; subsequent stray nn_done ignored (state IDLE).

Configuration
REQ-034 Macro RDN_FP_QUEUE_ARGMAX_EN defined: angle_idx registered on nn_done as index of lowest set bit of nn_angle, MSB=1 with low bits 0 when nn_angle=0.
REQ-035 Macro undefined: angle_idx tied to 0, no encoder logic.

Structure
REQ-036 Shared package rdn_pkg: FSM state enum, default IMG_H/IMG_W/PIX_W/NUM_ANG constants, image-size localparam.
REQ-037 One sub-module rdn_img_ring: DEPTH-slot storage, pointers, count, full/empty; FSM and weight tracking stay in top.

Verification
REQ-038 No weight_valid, push 2 images -> no nn_start, in_ready stays 1, occupancy=2.
REQ-039 weight_valid=1, push image A (all 0x11), nn_done 10 cycles after nn_start with nn_angle bit 7 -> out_valid, q=A, angle_out bit7, angle_idx=7 (macro on) / 0 (off).
REQ-040 Push DEPTH=4 images with out_ready=0 -> in_ready=0 after 4th, fifth held; pop -> in_ready=1 next cycle, images emerge in order.
REQ-041 load_weights pulse during RUN -> current result delivered, next nn_start only after weight_valid reasserted.
REQ-042 Simultaneous push and pop at cnt=2 -> cnt stays 2, order preserved.
REQ-043 rst_n asserted mid-RUN then nn_done pulse -> out_valid stays 0, occupancy=0.
